wide_word_serializer: RTL and testbench
=======================================

# wide_word_serializer

- Splits a WIDTH-bit word into NUM_SLICES equal slices of at most MAX_WIDTH bits and streams them over a narrow valid/ready bus, OUT_LANES slices per beat.
- Slice count uses the same power-of-two rule as our existing width-derivation code, now shared in a package and usable at elaboration.
- Adds a holding register, a beat counter, selectable slice order and back-to-back throughput.
- Sits between wide datapath producers and narrow link or debug ports.

## Interface
Parameters:
- WIDTH, 33: input word width, 1 or more.
- MAX_WIDTH, 11: maximum bits per slice, 1 or more.
- OUT_LANES, 2: slices per output beat. Power of two. Elaboration error if it exceeds NUM_SLICES.
- MSB_FIRST, 0: 0 sends the least-significant beat first; 1 sends the most-significant beat first.
- Derived, not overridable:
  - NUM_SLICES: smallest power of two n with ceil(WIDTH/n) ≤ MAX_WIDTH.
  - SLICE_W = ceil(WIDTH/NUM_SLICES).
  - BEATS = NUM_SLICES/OUT_LANES.
  - IDX_W = max(1, clog2(BEATS)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  serializer can accept a word.
- in_data  in  WIDTH  input word.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  OUT_LANES*SLICE_W  current beat. Lane 0 occupies the LSBs.
- out_idx  out  IDX_W  index of the current beat within the word, in slice order.
- out_last  out  1  current beat is the final beat of the word.

## Operation
- The word is zero-extended to NUM_SLICES*SLICE_W bits. Slice k is bits [k*SLICE_W +: SLICE_W].
- Beat b carries slices b*OUT_LANES .. b*OUT_LANES+OUT_LANES-1. Lane j of the beat carries slice b*OUT_LANES+j.
- Transmission order:
  - MSB_FIRST=0: b = 0..BEATS-1.
  - MSB_FIRST=1: b = BEATS-1..0.
  - out_idx always reports b, not the transmit position.
- States:
  - IDLE: out_valid=0.
  - SEND: out_valid=1.
- Transitions:
  - IDLE→SEND on in accept (in_valid and in_ready).
  - In SEND, an out accept (out_valid and out_ready) with out_last=0 advances to the next beat.
  - In SEND, an out accept with out_last=1 goes to SEND if a new word is accepted in the same cycle, otherwise to IDLE.
- in_ready = !rst and (IDLE, or out accept with out_last=1).
  - in_ready is combinational from out_ready.
  - No other comb paths.
- in_data is captured in the holding register on accept only. Beat content is stable while out_valid=1 and out_ready=0.
- out_last = 1 exactly on the final transmitted beat. When BEATS=1, every beat is last.
- Reset values (while rst high and the cycle after):
  - out_valid=0, out_last=0, out_idx=0, out_data=0, in_ready=0.
  - Beat counter 0, state IDLE.
- Reset asserted mid-word: the partially sent word is discarded, and no further beats of it appear after reset deasserts.
- A beat counter is kept only when BEATS>1. With BEATS=1 the block is a one-deep registered pipeline stage.

## Timing
- Latency: in accept at edge N gives out_valid=1 with the first beat after edge N.
- Beat advance: an out accept at edge N presents the next beat after edge N.
- Throughput: one beat per cycle when out_ready is held high.
  - BEATS cycles per word.
  - No bubble between consecutive words.
- out_valid, once high, never drops without an out accept, except on rst.
- out_data, out_idx and out_last are register outputs.

## Structure
- Package wide_serializer_pkg:
  - constant functions num_slices(width, max_width), ceil_div(a,b) and clog2_min1(x).
  - the typedef for the state enum {IDLE, SEND}.
- The constant function uses a while loop, evaluated at elaboration, as the existing code does.
- Sub-module slice_select: combinational selection of beat b from the padded word. Instantiated once.
- Top level holds the state register, beat counter, holding register and handshake logic.

## Test plan
- Defaults (WIDTH=33, MAX_WIDTH=11, OUT_LANES=2):
  - Check NUM_SLICES=4, SLICE_W=9, BEATS=2.
  - Send in_data=33'h1_2345_6789 with out_ready=1.
  - Expect beat0 out_data=18'h16789, idx 0, last 0.
  - Expect beat1 out_data=18'h048D1, idx 1, last 1.
- Same word with MSB_FIRST=1:
  - Expect 18'h048D1 (idx 1, last 0), then 18'h16789 (idx 0, last 1).
- Backpressure: hold out_ready=0 for 5 cycles on beat0.
  - out_data, out_idx and out_last stay stable.
  - in_ready=0 throughout.
- Back-to-back words A then B with in_valid and out_ready held at 1:
  - in_ready=1 on A's last beat.
  - Beats appear A0 A1 B0 B1 on four consecutive cycles with no gap.
- Assert rst after beat0 of a word:
  - Next cycle out_valid=0, in_ready=0.
  - After release: in_ready=1 and no stale beat1 appears.
- WIDTH=8, MAX_WIDTH=11, OUT_LANES=1:
  - NUM_SLICES=1, BEATS=1.
  - Word 8'hA5 gives one beat 8'hA5 with last=1, one cycle after accept.

Source files
------------

// File: rtl/wide_serializer_pkg.sv
// Shared width-derivation helpers and FSM state type for the wide word serializer.
// All functions are constant functions and are evaluated at elaboration.
package wide_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Doubling stops once a slice is a single bit, so a bad max_width cannot hang elaboration.
    function automatic int num_slices(input int width, input int max_width);
        int n = 1;
        while ((ceil_div(width, n) > max_width) && (n < width)) begin
            n = n * 2;
        end
        return n;
    endfunction

    function automatic int clog2_min1(input int x);
        int r = 0;
        while ((1 << r) < x) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wide_word_serializer_if.sv
// Wide-in / narrow-out valid/ready bundle for the wide word serializer.
// slave is the serializer side, master is the producer/consumer environment side.
interface wide_word_serializer_if #(
    parameter int WIDTH     = 33,
    parameter int MAX_WIDTH = 11,
    parameter int OUT_LANES = 2
);
    localparam int NUM_SLICES = wide_serializer_pkg::num_slices(WIDTH, MAX_WIDTH);
    localparam int SLICE_W    = wide_serializer_pkg::ceil_div(WIDTH, NUM_SLICES);
    localparam int BEATS      = NUM_SLICES / OUT_LANES;
    localparam int IDX_W      = wide_serializer_pkg::clog2_min1(BEATS);
    localparam int BEAT_W     = OUT_LANES * SLICE_W;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_idx,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last
    );

endinterface

// File: rtl/wide_word_serializer_slice_select.sv
// Picks beat 'beat' (OUT_LANES adjacent slices, lane 0 in the LSBs) out of the
// zero-extended input word. Purely combinational.
module slice_select #(
    parameter int WIDTH      = 33,
    parameter int NUM_SLICES = 4,
    parameter int SLICE_W    = 9,
    parameter int OUT_LANES  = 2,
    parameter int IDX_W      = 1
) (
    input  logic [WIDTH-1:0]               word,
    input  logic [IDX_W-1:0]               beat,
    output logic [OUT_LANES*SLICE_W-1:0]   data
);
    localparam int BEATS  = NUM_SLICES / OUT_LANES;
    localparam int BEAT_W = OUT_LANES * SLICE_W;
    localparam int PAD_W  = NUM_SLICES * SLICE_W;

    logic [PAD_W-1:0] padded;

    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = word;
    end

    // Slices of one beat are contiguous, so a beat is a single aligned part-select.
    always_comb begin
        data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat == IDX_W'(b)) begin
                data = padded[b*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: rtl/wide_word_serializer.sv
// Wide word serializer: captures a WIDTH-bit word and streams it as BEATS narrow
// beats of OUT_LANES slices each, with back-to-back words and no inter-word bubble.
module wide_word_serializer #(
    parameter int WIDTH     = 33,
    parameter int MAX_WIDTH = 11,
    parameter int OUT_LANES = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    wide_word_serializer_if.slave bus
);
    import wide_serializer_pkg::*;

    localparam int NUM_SLICES = num_slices(WIDTH, MAX_WIDTH);
    localparam int SLICE_W    = ceil_div(WIDTH, NUM_SLICES);
    localparam int BEATS      = NUM_SLICES / OUT_LANES;
    localparam int IDX_W      = clog2_min1(BEATS);
    localparam int BEAT_W     = OUT_LANES * SLICE_W;
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(BEATS - 1);

    if ((WIDTH < 1) || (MAX_WIDTH < 1)) begin : g_bad_width
        $error("wide_word_serializer: WIDTH and MAX_WIDTH must be at least 1");
    end
    if ((OUT_LANES < 1) || ((OUT_LANES & (OUT_LANES - 1)) != 0)) begin : g_bad_lanes
        $error("wide_word_serializer: OUT_LANES must be a power of two");
    end
    if (OUT_LANES > NUM_SLICES) begin : g_too_many_lanes
        $error("wide_word_serializer: OUT_LANES exceeds NUM_SLICES");
    end

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  pos;
    logic [IDX_W-1:0]  next_pos;
    logic [IDX_W-1:0]  sel_beat;
    logic [WIDTH-1:0]  hold;
    logic [WIDTH-1:0]  sel_word;
    logic [BEAT_W-1:0] beat_data;
    logic [BEAT_W-1:0] out_data_r;
    logic [IDX_W-1:0]  out_idx_r;
    logic              out_last_r;
    logic              in_ready_c;
    logic              in_acc;
    logic              out_acc;
    logic              load;

    assign out_acc    = (state == SEND) && bus.out_ready;
    assign in_ready_c = !rst && ((state == IDLE) || (out_acc && out_last_r));
    assign in_acc     = bus.in_valid && in_ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // pos is the transmit position; load means the output registers take a new beat.
    always_comb begin
        next_state = state;
        next_pos   = pos;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_acc) begin
                    next_state = SEND;
                    next_pos   = '0;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (out_acc) begin
                    if (!out_last_r) begin
                        next_pos = pos + 1'b1;
                        load     = 1'b1;
                    end else if (in_acc) begin
                        next_pos = '0;
                        load     = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The first beat of a fresh word comes straight from in_data, later beats from the holding register.
    assign sel_word = in_acc ? bus.in_data : hold;
    assign sel_beat = MSB_FIRST ? (LAST_POS - next_pos) : next_pos;

    slice_select #(
        .WIDTH      (WIDTH),
        .NUM_SLICES (NUM_SLICES),
        .SLICE_W    (SLICE_W),
        .OUT_LANES  (OUT_LANES),
        .IDX_W      (IDX_W)
    ) u_slice_select (
        .word (sel_word),
        .beat (sel_beat),
        .data (beat_data)
    );

    if (BEATS > 1) begin : g_beat_counter
        always_ff @(posedge clk) begin
            if (rst) begin
                pos <= '0;
            end else begin
                pos <= next_pos;
            end
        end
    end else begin : g_single_beat
        assign pos = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            out_data_r <= '0;
            out_idx_r  <= '0;
            out_last_r <= 1'b0;
        end else begin
            if (in_acc) begin
                hold <= bus.in_data;
            end
            if (load) begin
                out_data_r <= beat_data;
                out_idx_r  <= sel_beat;
                out_last_r <= (next_pos == LAST_POS);
            end else if (next_state == IDLE) begin
                out_data_r <= '0;
                out_idx_r  <= '0;
                out_last_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_wide_word_serializer.sv
// Directed bench: LSB-first, MSB-first and single-beat serializers side by side,
// table-driven word vectors plus backpressure, back-to-back and reset sequences.
module tb_wide_word_serializer;

    typedef struct {
        logic [32:0] word;
        logic        msb;
        logic [17:0] d0;
        logic        i0;
        logic        l0;
        logic [17:0] d1;
        logic        i1;
        logic        l1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    wide_word_serializer_if #(.WIDTH(33), .MAX_WIDTH(11), .OUT_LANES(2)) bus_a ();
    wide_word_serializer_if #(.WIDTH(33), .MAX_WIDTH(11), .OUT_LANES(2)) bus_b ();
    wide_word_serializer_if #(.WIDTH(8),  .MAX_WIDTH(11), .OUT_LANES(1)) bus_c ();

    wide_word_serializer #(.WIDTH(33), .MAX_WIDTH(11), .OUT_LANES(2), .MSB_FIRST(1'b0)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    wide_word_serializer #(.WIDTH(33), .MAX_WIDTH(11), .OUT_LANES(2), .MSB_FIRST(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    wide_word_serializer #(.WIDTH(8), .MAX_WIDTH(11), .OUT_LANES(1), .MSB_FIRST(1'b0)) dut_c (
        .clk (clk), .rst (rst), .bus (bus_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic msb, input logic valid, input logic [32:0] data, input logic ready);
        if (msb) begin
            bus_b.in_valid  = valid;
            bus_b.in_data   = data;
            bus_b.out_ready = ready;
        end else begin
            bus_a.in_valid  = valid;
            bus_a.in_data   = data;
            bus_a.out_ready = ready;
        end
    endtask

    function automatic logic [17:0] rd_data(input logic msb);
        return msb ? bus_b.out_data : bus_a.out_data;
    endfunction
    function automatic logic rd_valid(input logic msb);
        return msb ? bus_b.out_valid : bus_a.out_valid;
    endfunction
    function automatic logic rd_idx(input logic msb);
        return msb ? bus_b.out_idx[0] : bus_a.out_idx[0];
    endfunction
    function automatic logic rd_last(input logic msb);
        return msb ? bus_b.out_last : bus_a.out_last;
    endfunction
    function automatic logic rd_in_ready(input logic msb);
        return msb ? bus_b.in_ready : bus_a.in_ready;
    endfunction

    initial begin
        vecs[0] = '{33'h1_2345_6789, 1'b0, 18'h16789, 1'b0, 1'b0, 18'h048D1, 1'b1, 1'b1};
        vecs[1] = '{33'h1_2345_6789, 1'b1, 18'h048D1, 1'b1, 1'b0, 18'h16789, 1'b0, 1'b1};
        vecs[2] = '{33'h1_FFFF_FFFF, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 18'h07FFF, 1'b1, 1'b1};
        vecs[3] = '{33'h0_0000_0000, 1'b0, 18'h00000, 1'b0, 1'b0, 18'h00000, 1'b1, 1'b1};
        vecs[4] = '{33'h1_FFFF_FFFF, 1'b1, 18'h07FFF, 1'b1, 1'b0, 18'h3FFFF, 1'b0, 1'b1};
        vecs[5] = '{33'h1_0000_0000, 1'b0, 18'h00000, 1'b0, 1'b0, 18'h04000, 1'b1, 1'b1};
        vecs[6] = '{33'h0_0003_FFFF, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 18'h00000, 1'b1, 1'b1};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        bus_c.in_valid  = 1'b0;
        bus_c.in_data   = '0;
        bus_c.out_ready = 1'b0;

        repeat (3) tick();
        checkOutput("rst_a_valid", bus_a.out_valid, 0);
        checkOutput("rst_a_in_ready", bus_a.in_ready, 0);
        checkOutput("rst_a_data", bus_a.out_data, 0);
        checkOutput("rst_a_idx", bus_a.out_idx, 0);
        checkOutput("rst_a_last", bus_a.out_last, 0);
        checkOutput("rst_b_valid", bus_b.out_valid, 0);
        checkOutput("rst_c_valid", bus_c.out_valid, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_a_in_ready", bus_a.in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            tick();
            applyStimulus(vecs[i].msb, 1'b1, vecs[i].word, 1'b1);
            #1;
            checkOutput($sformatf("v%0d_in_ready", i), rd_in_ready(vecs[i].msb), 1);
            tick();
            applyStimulus(vecs[i].msb, 1'b0, '0, 1'b1);
            #1;
            checkOutput($sformatf("v%0d_b0_valid", i), rd_valid(vecs[i].msb), 1);
            checkOutput($sformatf("v%0d_b0_data", i), rd_data(vecs[i].msb), vecs[i].d0);
            checkOutput($sformatf("v%0d_b0_idx", i), rd_idx(vecs[i].msb), vecs[i].i0);
            checkOutput($sformatf("v%0d_b0_last", i), rd_last(vecs[i].msb), vecs[i].l0);
            tick();
            checkOutput($sformatf("v%0d_b1_valid", i), rd_valid(vecs[i].msb), 1);
            checkOutput($sformatf("v%0d_b1_data", i), rd_data(vecs[i].msb), vecs[i].d1);
            checkOutput($sformatf("v%0d_b1_idx", i), rd_idx(vecs[i].msb), vecs[i].i1);
            checkOutput($sformatf("v%0d_b1_last", i), rd_last(vecs[i].msb), vecs[i].l1);
            tick();
            checkOutput($sformatf("v%0d_idle_valid", i), rd_valid(vecs[i].msb), 0);
            applyStimulus(vecs[i].msb, 1'b0, '0, 1'b0);
        end

        // Backpressure on beat 0: outputs must hold and no new word may be taken.
        tick();
        applyStimulus(1'b0, 1'b1, 33'h1_2345_6789, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 33'h0_DEAD_BEEF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("bp%0d_valid", c), bus_a.out_valid, 1);
            checkOutput($sformatf("bp%0d_data", c), bus_a.out_data, 18'h16789);
            checkOutput($sformatf("bp%0d_idx", c), bus_a.out_idx, 0);
            checkOutput($sformatf("bp%0d_last", c), bus_a.out_last, 0);
            checkOutput($sformatf("bp%0d_in_ready", c), bus_a.in_ready, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("bp_release_in_ready", bus_a.in_ready, 0);
        tick();
        checkOutput("bp_b1_data", bus_a.out_data, 18'h048D1);
        checkOutput("bp_b1_last", bus_a.out_last, 1);
        checkOutput("bp_b1_in_ready", bus_a.in_ready, 1);
        tick();
        checkOutput("bp_idle_valid", bus_a.out_valid, 0);

        // Back-to-back words with no bubble between A1 and B0.
        applyStimulus(1'b0, 1'b1, 33'h1_2345_6789, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 33'h1_FFFF_FFFF, 1'b1);
        #1;
        checkOutput("b2b_a0_data", bus_a.out_data, 18'h16789);
        checkOutput("b2b_a0_in_ready", bus_a.in_ready, 0);
        tick();
        checkOutput("b2b_a1_data", bus_a.out_data, 18'h048D1);
        checkOutput("b2b_a1_last", bus_a.out_last, 1);
        checkOutput("b2b_a1_in_ready", bus_a.in_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("b2b_b0_valid", bus_a.out_valid, 1);
        checkOutput("b2b_b0_data", bus_a.out_data, 18'h3FFFF);
        checkOutput("b2b_b0_idx", bus_a.out_idx, 0);
        tick();
        checkOutput("b2b_b1_data", bus_a.out_data, 18'h07FFF);
        checkOutput("b2b_b1_last", bus_a.out_last, 1);
        tick();
        checkOutput("b2b_idle_valid", bus_a.out_valid, 0);

        // Reset after beat 0: the rest of the word must be dropped.
        applyStimulus(1'b0, 1'b1, 33'h1_2345_6789, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("mid_rst_b0_valid", bus_a.out_valid, 1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_valid", bus_a.out_valid, 0);
        checkOutput("mid_rst_in_ready", bus_a.in_ready, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("mid_rst_release_in_ready", bus_a.in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("mid_rst_no_stale%0d", c), bus_a.out_valid, 0);
        end

        // Single-beat configuration behaves as a one-deep register stage.
        bus_c.in_valid  = 1'b1;
        bus_c.in_data   = 8'hA5;
        bus_c.out_ready = 1'b1;
        #1;
        checkOutput("c_in_ready", bus_c.in_ready, 1);
        tick();
        bus_c.in_valid = 1'b0;
        #1;
        checkOutput("c_valid", bus_c.out_valid, 1);
        checkOutput("c_data", bus_c.out_data, 8'hA5);
        checkOutput("c_idx", bus_c.out_idx, 0);
        checkOutput("c_last", bus_c.out_last, 1);
        tick();
        checkOutput("c_idle_valid", bus_c.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
